// File: rtl/taxi_eth_phy_10g_tx_if.sv
// 10GBASE-R PHY transmit interface: 64b/66b scrambler, optional PRBS31 test
// pattern, optional bit reversal and a configurable SERDES output pipeline.
module taxi_eth_phy_10g_tx_if #(
    parameter int DATA_W            = 64,
    parameter int HDR_W             = 2,
    parameter int GBX_IF_EN         = 0,
    parameter int BIT_REVERSE       = 0,
    parameter int SCRAMBLER_DISABLE = 0,
    parameter int PRBS31_EN         = 0,
    parameter int SERDES_PIPELINE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] encoded_tx_data,
    input  logic              encoded_tx_data_valid,
    input  logic [HDR_W-1:0]  encoded_tx_hdr,
    input  logic              encoded_tx_hdr_valid,
    output logic [DATA_W-1:0] serdes_tx_data,
    output logic              serdes_tx_data_valid,
    output logic [HDR_W-1:0]  serdes_tx_hdr,
    output logic              serdes_tx_hdr_valid,
    input  logic              cfg_tx_prbs31_enable
);

    localparam int TW = DATA_W + HDR_W;
    localparam int PW = DATA_W + HDR_W + 2;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "DATA_W must be 32 or 64");
    end
    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "HDR_W must be 2");
    end

    logic              dv;
    logic              prbs_active;
    logic [57:0]       scr_state_reg;
    logic [57:0]       scr_state_next;
    logic [30:0]       prbs_state_reg;
    logic [30:0]       prbs_state_next;
    logic [DATA_W-1:0] scr_data;
    logic [TW-1:0]     prbs_bits;
    logic [DATA_W-1:0] mux_data;
    logic [HDR_W-1:0]  mux_hdr;
    logic [DATA_W-1:0] rev_data;
    logic [HDR_W-1:0]  rev_hdr;
    logic [PW-1:0]     pipe_reg [0:SERDES_PIPELINE];
    logic              out_dv;
    logic              out_hv;

    assign dv          = (GBX_IF_EN != 0) ? encoded_tx_data_valid : 1'b1;
    assign prbs_active = (PRBS31_EN != 0) && cfg_tx_prbs31_enable;

    // Self-synchronous x^58+x^39+1 scrambler, bit 0 transmitted first.
    always_comb begin
        scr_state_next = scr_state_reg;
        scr_data       = '0;
        for (int i = 0; i < DATA_W; i++) begin
            scr_data[i]    = encoded_tx_data[i] ^ scr_state_next[38] ^ scr_state_next[57];
            scr_state_next = {scr_state_next[56:0], scr_data[i]};
        end
    end

    // Fibonacci PRBS31; the transmitted bit is the inverted feedback bit.
    always_comb begin
        prbs_state_next = prbs_state_reg;
        prbs_bits       = '0;
        for (int i = 0; i < TW; i++) begin
            prbs_bits[i]    = ~(prbs_state_next[30] ^ prbs_state_next[27]);
            prbs_state_next = {prbs_state_next[29:0], ~prbs_bits[i]};
        end
    end

    always_comb begin
        mux_data = (SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scr_data;
        mux_hdr  = encoded_tx_hdr;
        if (prbs_active) begin
            {mux_data, mux_hdr} = prbs_bits;
        end
    end

    genvar gi;
    for (gi = 0; gi < DATA_W; gi++) begin : g_rev_data
        assign rev_data[gi] = (BIT_REVERSE != 0) ? mux_data[DATA_W-1-gi] : mux_data[gi];
    end
    for (gi = 0; gi < HDR_W; gi++) begin : g_rev_hdr
        assign rev_hdr[gi] = (BIT_REVERSE != 0) ? mux_hdr[HDR_W-1-gi] : mux_hdr[gi];
    end

    // Scrambler state is frozen while PRBS31 owns the line, so normal traffic
    // resumes with the same state it left off with.
    always_ff @(posedge clk) begin
        if (dv && !prbs_active) begin
            scr_state_reg <= scr_state_next;
        end
        if (dv && prbs_active) begin
            prbs_state_reg <= prbs_state_next;
        end
        if (rst) begin
            scr_state_reg  <= '1;
            prbs_state_reg <= '1;
        end
    end

    // Stage 0 is the resettable output register; later stages are free-running.
    always_ff @(posedge clk) begin
        for (int s = SERDES_PIPELINE; s > 0; s--) begin
            pipe_reg[s] <= pipe_reg[s-1];
        end
        pipe_reg[0] <= {encoded_tx_hdr_valid, dv, rev_hdr, rev_data};
        if (rst) begin
            pipe_reg[0] <= '0;
        end
    end

    assign {out_hv, out_dv, serdes_tx_hdr, serdes_tx_data} = pipe_reg[SERDES_PIPELINE];

    assign serdes_tx_data_valid = (GBX_IF_EN != 0) ? out_dv : 1'b1;
    assign serdes_tx_hdr_valid  = (GBX_IF_EN != 0 || DATA_W == 32) ? out_hv : 1'b1;

endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_if.sv
// Randomized bench for taxi_eth_phy_10g_tx_if: three configurations driven in
// parallel and compared against a bit-stream reference model.
module tb_taxi_eth_phy_10g_tx_if;

    localparam int NCYC = 700;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  = 1'b1;
    logic [63:0] data = '0;
    logic [1:0]  hdr  = '0;
    logic        dv   = 1'b0;
    logic        hv   = 1'b0;
    logic        cfg  = 1'b0;

    logic [63:0] m_data, b_data, p_data;
    logic [1:0]  m_hdr, b_hdr, p_hdr;
    logic        m_dv, b_dv, p_dv;
    logic        m_hv, b_hv, p_hv;

    // Gearbox qualifiers, PRBS31 and a 2-deep pipeline (latency 3).
    taxi_eth_phy_10g_tx_if #(
        .GBX_IF_EN(1), .PRBS31_EN(1), .SERDES_PIPELINE(2)
    ) u_main (
        .clk(clk), .rst(rst),
        .encoded_tx_data(data), .encoded_tx_data_valid(dv),
        .encoded_tx_hdr(hdr), .encoded_tx_hdr_valid(hv),
        .serdes_tx_data(m_data), .serdes_tx_data_valid(m_dv),
        .serdes_tx_hdr(m_hdr), .serdes_tx_hdr_valid(m_hv),
        .cfg_tx_prbs31_enable(cfg)
    );

    // Scrambler bypass with bit reversal.
    taxi_eth_phy_10g_tx_if #(
        .BIT_REVERSE(1), .SCRAMBLER_DISABLE(1)
    ) u_byp (
        .clk(clk), .rst(rst),
        .encoded_tx_data(data), .encoded_tx_data_valid(dv),
        .encoded_tx_hdr(hdr), .encoded_tx_hdr_valid(hv),
        .serdes_tx_data(b_data), .serdes_tx_data_valid(b_dv),
        .serdes_tx_hdr(b_hdr), .serdes_tx_hdr_valid(b_hv),
        .cfg_tx_prbs31_enable(cfg)
    );

    // Default parameters: qualifiers and PRBS31 request must be ignored.
    taxi_eth_phy_10g_tx_if u_plain (
        .clk(clk), .rst(rst),
        .encoded_tx_data(data), .encoded_tx_data_valid(dv),
        .encoded_tx_hdr(hdr), .encoded_tx_hdr_valid(hv),
        .serdes_tx_data(p_data), .serdes_tx_data_valid(p_dv),
        .serdes_tx_hdr(p_hdr), .serdes_tx_hdr_valid(p_hv),
        .cfg_tx_prbs31_enable(cfg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: transmitted line bits kept as a plain stream, so each
    // new bit is computed from the bits sent 39/58 (or 28/31) positions back.
    bit scr_s [2][65536];
    int scr_n [2];
    bit prbs_s [65536];
    int prbs_n;

    logic [63:0] e_d  [3][NCYC];
    logic [1:0]  e_h  [3][NCYC];
    logic        e_v  [3][NCYC];
    logic        e_hv [3][NCYC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic void seed_scr(input int m);
        for (int i = 0; i < 58; i++) scr_s[m][i] = 1'b1;
        scr_n[m] = 58;
    endfunction

    function automatic void seed_prbs();
        for (int i = 0; i < 31; i++) prbs_s[i] = 1'b1;
        prbs_n = 31;
    endfunction

    function automatic logic [63:0] scramble(input int m, input logic [63:0] d, input bit commit);
        logic [63:0] r;
        int n;
        r = '0;
        n = scr_n[m];
        for (int i = 0; i < 64; i++) begin
            scr_s[m][n+i] = d[i] ^ scr_s[m][n+i-39] ^ scr_s[m][n+i-58];
            r[i] = scr_s[m][n+i];
        end
        if (commit) scr_n[m] = n + 64;
        return r;
    endfunction

    function automatic logic [65:0] prbs_gen(input bit commit);
        logic [65:0] r;
        r = '0;
        for (int k = 0; k < 66; k++) begin
            prbs_s[prbs_n+k] = prbs_s[prbs_n+k-31] ^ prbs_s[prbs_n+k-28];
            r[k] = ~prbs_s[prbs_n+k];
        end
        if (commit) prbs_n = prbs_n + 66;
        return r;
    endfunction

    // Value each instance's output register takes at this clock edge.
    task automatic model_step();
        logic [65:0] pb;
        for (int m = 1; m < 3; m++) begin
            e_v[m][cyc]  = 1'b1;
            e_hv[m][cyc] = 1'b1;
        end
        if (rst) begin
            for (int m = 0; m < 3; m++) begin
                e_d[m][cyc] = '0;
                e_h[m][cyc] = '0;
            end
            e_v[0][cyc]  = 1'b0;
            e_hv[0][cyc] = 1'b0;
            seed_scr(0);
            seed_scr(1);
            seed_prbs();
        end else begin
            if (cfg) begin
                pb = prbs_gen(dv);
                e_d[0][cyc] = pb[65:2];
                e_h[0][cyc] = pb[1:0];
            end else begin
                e_d[0][cyc] = scramble(0, data, dv);
                e_h[0][cyc] = hdr;
            end
            e_v[0][cyc]  = dv;
            e_hv[0][cyc] = hv;
            e_d[1][cyc]  = {<<{data}};
            e_h[1][cyc]  = {<<{hdr}};
            e_d[2][cyc]  = scramble(1, data, 1'b1);
            e_h[2][cyc]  = hdr;
        end
    endtask

    initial begin
        for (cyc = 0; cyc < NCYC; cyc++) begin
            rst = (cyc < 4) || (cyc == 400);
            if (cyc == 5) begin
                data = 64'h1E; hdr = 2'b10; dv = 1'b1; hv = 1'b1;
            end else if (cyc == 6) begin
                data = 64'h1; hdr = 2'b01; dv = 1'b1; hv = 1'b1;
            end else begin
                data = {$urandom, $urandom};
                hdr  = 2'($urandom_range(0, 3));
                dv   = ($urandom_range(0, 3) != 0);
                hv   = 1'($urandom_range(0, 1));
            end
            if (cyc >= 50 && cyc <= 52) dv = 1'b0;
            cfg = (cyc >= 200 && cyc < 300) || (cyc >= 500 && cyc < 520);

            @(posedge clk);
            model_step();
            #1;

            if (cyc >= 2) begin
                check("main_data", m_data, e_d[0][cyc-2]);
                check("main_hdr", 64'(m_hdr), 64'(e_h[0][cyc-2]));
                check("main_dv", 64'(m_dv), 64'(e_v[0][cyc-2]));
                check("main_hv", 64'(m_hv), 64'(e_hv[0][cyc-2]));
            end
            check("byp_data", b_data, e_d[1][cyc]);
            check("byp_hdr", 64'(b_hdr), 64'(e_h[1][cyc]));
            check("byp_dv", 64'(b_dv), 64'(e_v[1][cyc]));
            check("byp_hv", 64'(b_hv), 64'(e_hv[1][cyc]));
            check("plain_data", p_data, e_d[2][cyc]);
            check("plain_hdr", 64'(p_hdr), 64'(e_h[2][cyc]));
            check("plain_dv", 64'(p_dv), 64'(e_v[2][cyc]));
            check("plain_hv", 64'(p_hv), 64'(e_hv[2][cyc]));

            // Directed points with hand-derived values.
            if (cyc == 3 || cyc == 402) begin
                check("rst_main_data", m_data, 64'h0);
                check("rst_main_dv", 64'(m_dv), 64'h0);
            end
            if (cyc == 400) check("rst_byp_data", b_data, 64'h0);
            if (cyc == 5) begin
                check("rev_1e_data", b_data, 64'h7800_0000_0000_0000);
                check("rev_1e_hdr", 64'(b_hdr), 64'h1);
            end
            if (cyc == 6) begin
                check("rev_1_data", b_data, 64'h8000_0000_0000_0000);
                check("rev_1_hdr", 64'(b_hdr), 64'h2);
            end
            if (cyc >= 52 && cyc <= 54) check("gbx_hold_dv", 64'(m_dv), 64'h0);

            $display("cyc=%0d rst=%0b dv=%0b prbs=%0b in=%h/%h main=%h/%h byp=%h plain=%h",
                     cyc, rst, dv, cfg, data, hdr, m_data, m_hdr, b_data, p_data);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/taxi_eth_phy_10g_tx_if.md
TAXI_ETH_PHY_10G_TX_IF -- requirements
Module: taxi_eth_phy_10g_tx_if

Interface
REQ-001 SHALL have parameter DATA_W, default 64, SERDES data width; only 32 or 64 legal, other values are a fatal elaboration error.
REQ-002 SHALL have parameter HDR_W, default 2, sync header width; any value other than 2 is a fatal elaboration error.
REQ-003 SHALL have parameter GBX_IF_EN, default 0, which enables the gearbox valid qualifiers.
REQ-004 SHALL have parameter BIT_REVERSE, default 0, which reverses the bit order of serdes data and header.
REQ-005 SHALL have parameter SCRAMBLER_DISABLE, default 0, which bypasses the scrambler.
REQ-006 SHALL have parameter PRBS31_EN, default 0, which builds the PRBS31 generator.
REQ-007 SHALL have parameter SERDES_PIPELINE, default 0, giving the number of extra output register stages.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port encoded_tx_data, input, DATA_W bits: 64b/66b encoded block payload, unscrambled.
REQ-011 SHALL have port encoded_tx_data_valid, input, 1 bit: payload qualifier, used only when GBX_IF_EN=1.
REQ-012 SHALL have port encoded_tx_hdr, input, HDR_W bits: sync header.
REQ-013 SHALL have port encoded_tx_hdr_valid, input, 1 bit: header qualifier, used only when GBX_IF_EN=1 or DATA_W=32.
REQ-014 SHALL have port serdes_tx_data, output, DATA_W bits: scrambled payload sent to the SERDES.
REQ-015 SHALL have port serdes_tx_data_valid, output, 1 bit: tied to 1 unless GBX_IF_EN=1.
REQ-016 SHALL have port serdes_tx_hdr, output, HDR_W bits: header sent to the SERDES.
REQ-017 SHALL have port serdes_tx_hdr_valid, output, 1 bit: tied to 1 unless GBX_IF_EN=1 or DATA_W=32.
REQ-018 SHALL have port cfg_tx_prbs31_enable, input, 1 bit: selects PRBS31 test-pattern output.

Function
REQ-019 SHALL define the internal data-valid qualifier dv as encoded_tx_data_valid when GBX_IF_EN=1, else constant 1.
REQ-020 SHALL scramble with the self-synchronous polynomial x^58+x^39+1, processing bit 0 first: out[i] = in[i] ^ s[38] ^ s[57], with the state shifted by the scrambled output bit.
REQ-021 SHALL update the 58-bit scrambler state only on cycles where dv=1, and hold it otherwise.
REQ-022 SHALL pass the header unscrambled, and SHALL pass the payload unmodified when SCRAMBLER_DISABLE=1.
REQ-023 SHALL, when PRBS31_EN=1 and cfg_tx_prbs31_enable=1, generate PRBS31 (x^31+x^28+1, non-Galois, bit 0 first, output inverted) across DATA_W+HDR_W bits, with the header in the low HDR_W bits and data in the upper bits.
REQ-024 SHALL, in PRBS31 mode, replace both the scrambled data and the header with the PRBS31 output.
REQ-025 SHALL advance the 31-bit PRBS state only on cycles where dv=1 and PRBS31 mode is active.
REQ-026 SHALL ignore cfg_tx_prbs31_enable when PRBS31_EN=0.
REQ-027 SHALL register data, header and both valids in one output stage, followed by SERDES_PIPELINE further register stages; total latency is 1+SERDES_PIPELINE cycles.
REQ-028 SHALL apply BIT_REVERSE after scrambling/PRBS and before the pipeline, mapping out[n] = in[W-1-n] separately for data and for header.
REQ-029 SHALL leave the scrambler state unchanged by PRBS31 mode, so that scrambling resumes from the held state when the mode is exited.
REQ-030 SHALL make pipeline stages shift every cycle, regardless of the valid signals.

Reset
REQ-031 SHALL, on rst=1, set the scrambler state to all-ones and the PRBS31 state to all-ones.
REQ-032 SHALL, on rst=1, clear the output-stage data, header and valid registers to 0.
REQ-033 SHALL not reset the pipeline stages; they flush within SERDES_PIPELINE cycles.
REQ-034 SHALL, on rst asserted mid-stream, restart scrambling from all-ones on the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover bypass: SCRAMBLER_DISABLE=1, data=64'h1E, hdr=2'b10 -> serdes_tx_data=64'h1E and serdes_tx_hdr=2'b10 exactly 1 cycle later.
REQ-036 SHALL cover loopback: 1000 random blocks through this block into the existing RX interface -> encoded_rx data/hdr match the input, delayed, after RX descrambler lock.
REQ-037 SHALL cover PRBS31: PRBS31_EN=1, cfg=1, looped into the RX checker with its cfg=1 -> rx_error_count=0; flipping 1 bit -> nonzero count.
REQ-038 SHALL cover BIT_REVERSE=1: SCRAMBLER_DISABLE=1, data=64'h1, hdr=2'b01 -> data=64'h8000_0000_0000_0000, hdr=2'b10.
REQ-039 SHALL cover gearbox hold: GBX_IF_EN=1, dv=0 for 3 cycles mid-stream -> scrambler state unchanged, serdes_tx_data_valid=0 on the matching output cycles.
REQ-040 SHALL cover reset: rst pulse during traffic -> outputs 0 on the next cycle; the first scrambled block matches a reference model seeded with all-ones; SERDES_PIPELINE=2 gives latency 3.
